// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EXE pipeline register: forwarding select encodings,
// field widths and the saturating counter increment.
package pipe_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned ALUC_W = 5;
    localparam int unsigned REG_W  = 5;

    localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_ALT = 2'b01;
    localparam logic [SEL_W-1:0] SEL_EXE = 2'b10;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b11;

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    // Increment that sticks at max instead of wrapping; counters up to 32 bits
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_fwd_mux4.sv
// 4:1 operand select driven by a forwarding select code.
module pipe_fwd_mux4
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] in_rf,
    input  logic [DATA_W-1:0] in_alt,
    input  logic [DATA_W-1:0] in_exe,
    input  logic [DATA_W-1:0] in_mem,
    output logic [DATA_W-1:0] y_c
);

    always_comb begin
        y_c = in_rf;
        unique case (sel)
            SEL_RF:  y_c = in_rf;
            SEL_ALT: y_c = in_alt;
            SEL_EXE: y_c = in_exe;
            SEL_MEM: y_c = in_mem;
            default: y_c = in_rf;
        endcase
    end

endmodule

// File: rtl/pipe_idexe_fwd_reg.sv
// ID/EXE pipeline register with operand forwarding, load-use bubble insertion and
// saturating bubble / forward performance counters.
module pipe_idexe_fwd_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_depen,
    input  logic              dwreg,
    input  logic              dm2reg,
    input  logic              dwmem,
    input  logic              djal,
    input  logic [ALUC_W-1:0] daluc,
    input  logic              dj,
    input  logic              dbeq,
    input  logic              dbne,
    input  logic [SEL_W-1:0]  a_depen,
    input  logic [SEL_W-1:0]  b_depen,
    input  logic [SEL_W-1:0]  store_depen,
    input  logic [DATA_W-1:0] da,
    input  logic [DATA_W-1:0] db,
    input  logic [DATA_W-1:0] dimm,
    input  logic [REG_W-1:0]  dsa,
    input  logic [REG_W-1:0]  drn,
    input  logic [DATA_W-1:0] dpc4,
    input  logic [DATA_W-1:0] exe_fwd,
    input  logic [DATA_W-1:0] mem_fwd,
    input  logic              cnt_clr,
    output logic              ewreg,
    output logic              em2reg,
    output logic              ewmem,
    output logic              ejal,
    output logic [ALUC_W-1:0] ealuc,
    output logic [DATA_W-1:0] ea,
    output logic [DATA_W-1:0] eb,
    output logic [DATA_W-1:0] est,
    output logic [DATA_W-1:0] epc4,
    output logic [REG_W-1:0]  ern,
    output logic              evalid,
    output logic              ex_is_uncond,
    output logic              ex_is_cond,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  fwd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] a_sel_c;
    logic [DATA_W-1:0] b_sel_c;
    logic [DATA_W-1:0] st_sel_c;
    logic              fwd_used_c;

    pipe_fwd_mux4 #(.DATA_W(DATA_W)) u_mux_a (
        .sel    (a_depen),
        .in_rf  (da),
        .in_alt (DATA_W'(dsa)),
        .in_exe (exe_fwd),
        .in_mem (mem_fwd),
        .y_c    (a_sel_c)
    );

    pipe_fwd_mux4 #(.DATA_W(DATA_W)) u_mux_b (
        .sel    (b_depen),
        .in_rf  (db),
        .in_alt (dimm),
        .in_exe (exe_fwd),
        .in_mem (mem_fwd),
        .y_c    (b_sel_c)
    );

    // Store data has no alternate source; SEL_ALT falls back to the register value
    pipe_fwd_mux4 #(.DATA_W(DATA_W)) u_mux_st (
        .sel    (store_depen),
        .in_rf  (db),
        .in_alt (db),
        .in_exe (exe_fwd),
        .in_mem (mem_fwd),
        .y_c    (st_sel_c)
    );

    assign fwd_used_c = a_depen[1] | b_depen[1] | store_depen[1];

    // Pipeline register: advance latches ID, stall loads a bubble
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ewreg        <= 1'b0;
            em2reg       <= 1'b0;
            ewmem        <= 1'b0;
            ejal         <= 1'b0;
            ealuc        <= '0;
            ea           <= '0;
            eb           <= '0;
            est          <= '0;
            epc4         <= '0;
            ern          <= '0;
            evalid       <= 1'b0;
            ex_is_uncond <= 1'b0;
            ex_is_cond   <= 1'b0;
        end else if (load_depen) begin
            ewreg        <= dwreg;
            em2reg       <= dm2reg;
            ewmem        <= dwmem;
            ejal         <= djal;
            ealuc        <= daluc;
            ea           <= a_sel_c;
            eb           <= b_sel_c;
            est          <= st_sel_c;
            epc4         <= dpc4;
            ern          <= djal ? REG_RA : drn;
            evalid       <= 1'b1;
            ex_is_uncond <= dj | djal;
            ex_is_cond   <= dbeq | dbne;
        end else begin
            ewreg        <= 1'b0;
            em2reg       <= 1'b0;
            ewmem        <= 1'b0;
            ejal         <= 1'b0;
            ealuc        <= '0;
            ea           <= '0;
            eb           <= '0;
            est          <= '0;
            epc4         <= '0;
            ern          <= '0;
            evalid       <= 1'b0;
            ex_is_uncond <= 1'b0;
            ex_is_cond   <= 1'b0;
        end
    end

    // Performance counters: clear beats bubble beats forward, one change per cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
            fwd_cnt    <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            fwd_cnt    <= '0;
        end else if (!load_depen) begin
            bubble_cnt <= CNT_W'(sat_inc(32'(bubble_cnt), 32'(CNT_MAX)));
        end else if (fwd_used_c) begin
            fwd_cnt    <= CNT_W'(sat_inc(32'(fwd_cnt), 32'(CNT_MAX)));
        end
    end

endmodule

// File: tb/tb_pipe_idexe_fwd_reg.sv
// Scoreboard bench for pipe_idexe_fwd_reg: expected EXE state is queued when ID inputs are
// driven and compared one clock later.
module tb_pipe_idexe_fwd_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_depen, dwreg, dm2reg, dwmem, djal, dj, dbeq, dbne, cnt_clr;
    logic [4:0]  daluc, dsa, drn;
    logic [1:0]  a_depen, b_depen, store_depen;
    logic [31:0] da, db, dimm, dpc4, exe_fwd, mem_fwd;
    logic        ewreg, em2reg, ewmem, ejal, evalid, ex_is_uncond, ex_is_cond;
    logic [4:0]  ealuc, ern;
    logic [31:0] ea, eb, est, epc4;
    logic [15:0] bubble_cnt, fwd_cnt;

    typedef struct {
        logic        wreg, m2reg, wmem, jal, valid, unc, cond;
        logic [4:0]  aluc, rn;
        logic [31:0] a, b, st, pc4;
        logic [15:0] bc, fc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_bc, m_fc;
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;

    pipe_idexe_fwd_reg dut (
        .clock(clock), .reset(reset), .load_depen(load_depen),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal), .daluc(daluc),
        .dj(dj), .dbeq(dbeq), .dbne(dbne),
        .a_depen(a_depen), .b_depen(b_depen), .store_depen(store_depen),
        .da(da), .db(db), .dimm(dimm), .dsa(dsa), .drn(drn), .dpc4(dpc4),
        .exe_fwd(exe_fwd), .mem_fwd(mem_fwd), .cnt_clr(cnt_clr),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ejal(ejal), .ealuc(ealuc),
        .ea(ea), .eb(eb), .est(est), .epc4(epc4), .ern(ern), .evalid(evalid),
        .ex_is_uncond(ex_is_uncond), .ex_is_cond(ex_is_cond),
        .bubble_cnt(bubble_cnt), .fwd_cnt(fwd_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        load_depen = 1'b1; dwreg = 0; dm2reg = 0; dwmem = 0; djal = 0; dj = 0; dbeq = 0; dbne = 0;
        cnt_clr = 0; daluc = '0; dsa = '0; drn = '0;
        a_depen = 2'b00; b_depen = 2'b00; store_depen = 2'b00;
        da = '0; db = '0; dimm = '0; dpc4 = '0; exe_fwd = '0; mem_fwd = '0;
    endtask

    // Reference behaviour of one edge, written from the block description
    function automatic exp_t predict();
        exp_t e;
        e = '{default: '0};
        if (load_depen) begin
            e.wreg = dwreg; e.m2reg = dm2reg; e.wmem = dwmem; e.jal = djal; e.aluc = daluc;
            case (a_depen)
                2'b00: e.a = da;
                2'b01: e.a = {27'b0, dsa};
                2'b10: e.a = exe_fwd;
                default: e.a = mem_fwd;
            endcase
            case (b_depen)
                2'b00: e.b = db;
                2'b01: e.b = dimm;
                2'b10: e.b = exe_fwd;
                default: e.b = mem_fwd;
            endcase
            e.st    = (store_depen == 2'b10) ? exe_fwd : (store_depen == 2'b11) ? mem_fwd : db;
            e.pc4   = dpc4;
            e.rn    = djal ? 5'd31 : drn;
            e.valid = 1'b1;
            e.unc   = dj | djal;
            e.cond  = dbeq | dbne;
        end
        if (cnt_clr) begin
            m_bc = '0; m_fc = '0;
        end else if (!load_depen) begin
            if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
        end else if (a_depen == 2'b10 || a_depen == 2'b11 || b_depen >= 2'b10 || store_depen >= 2'b10) begin
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end
        e.bc = m_bc; e.fc = m_fc;
        return e;
    endfunction

    // Drive is already set up; queue the prediction, clock once, check the popped entry
    task automatic step(input bit quiet = 1'b0);
        exp_t e;
        sb.push_back(predict());
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        if (quiet) begin
            chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bc));
            return;
        end
        chk("ewreg",  64'(ewreg),  64'(e.wreg));
        chk("em2reg", 64'(em2reg), 64'(e.m2reg));
        chk("ewmem",  64'(ewmem),  64'(e.wmem));
        chk("ejal",   64'(ejal),   64'(e.jal));
        chk("ealuc",  64'(ealuc),  64'(e.aluc));
        chk("ea",     64'(ea),     64'(e.a));
        chk("eb",     64'(eb),     64'(e.b));
        chk("est",    64'(est),    64'(e.st));
        chk("epc4",   64'(epc4),   64'(e.pc4));
        chk("ern",    64'(ern),    64'(e.rn));
        chk("evalid", 64'(evalid), 64'(e.valid));
        chk("ex_is_uncond", 64'(ex_is_uncond), 64'(e.unc));
        chk("ex_is_cond",   64'(ex_is_cond),   64'(e.cond));
        chk("bubble_cnt",   64'(bubble_cnt),   64'(e.bc));
        chk("fwd_cnt",      64'(fwd_cnt),      64'(e.fc));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({ewreg, em2reg, ewmem, ejal, evalid, ex_is_uncond, ex_is_cond}), 64'd0);
        chk({tag, "_ealuc_ern"}, 64'({ealuc, ern}), 64'd0);
        chk({tag, "_ea"}, 64'(ea), 64'd0);
        chk({tag, "_eb"}, 64'(eb), 64'd0);
        chk({tag, "_est"}, 64'(est), 64'd0);
        chk({tag, "_epc4"}, 64'(epc4), 64'd0);
        chk({tag, "_cnts"}, 64'({bubble_cnt, fwd_cnt}), 64'd0);
    endtask

    initial begin
        idle_inputs();
        m_bc = '0; m_fc = '0;
        reset = 1'b1;
        #12;
        check_all_zero("reset0");
        reset = 1'b0;

        // 1: build up ewreg=1 / fwd_cnt=5, then reset between edges
        for (int i = 0; i < 5; i++) begin
            dwreg = 1'b1; a_depen = 2'b10; exe_fwd = 32'(i + 100);
            step();
        end
        chk("pre_reset_fwd_cnt", 64'(fwd_cnt), 64'd5);
        chk("pre_reset_ewreg", 64'(ewreg), 64'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("reset_mid");
        m_bc = '0; m_fc = '0;
        #1 reset = 1'b0;
        idle_inputs();
        step();

        // 2: A mux over all selects
        da = 32'd1; exe_fwd = 32'd2; mem_fwd = 32'd3; dsa = 5'd7;
        a_depen = 2'b00; step();
        a_depen = 2'b10; step();
        a_depen = 2'b11; step();
        a_depen = 2'b01; step();

        // 3: store word with immediate B and forwarded store data
        idle_inputs();
        dwmem = 1'b1; b_depen = 2'b01; dimm = 32'h10; store_depen = 2'b10; exe_fwd = 32'hAB;
        db = 32'h55; daluc = 5'd2;
        step();

        // 4: stall with forwarding select active -> bubble only
        idle_inputs();
        load_depen = 1'b0; dwreg = 1'b1; dwmem = 1'b1; a_depen = 2'b10; exe_fwd = 32'h77;
        step();

        // 5: jal then bne
        idle_inputs();
        djal = 1'b1; drn = 5'd4; dpc4 = 32'h40; dwreg = 1'b1;
        step();
        idle_inputs();
        dbne = 1'b1; drn = 5'd9; dpc4 = 32'h44;
        step();

        // Mixed random traffic
        for (int i = 0; i < 60; i++) begin
            load_depen = ($urandom_range(0, 3) != 0);
            {dwreg, dm2reg, dwmem, djal, dj, dbeq, dbne} = 7'($urandom);
            cnt_clr = ($urandom_range(0, 15) == 0);
            daluc = 5'($urandom); dsa = 5'($urandom); drn = 5'($urandom);
            a_depen = 2'($urandom); b_depen = 2'($urandom); store_depen = 2'($urandom);
            da = $urandom; db = $urandom; dimm = $urandom; dpc4 = $urandom;
            exe_fwd = $urandom; mem_fwd = $urandom;
            step();
        end

        // 6: drive bubble_cnt to FFFE, then saturate, then clear during a bubble
        idle_inputs();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        load_depen = 1'b0;
        for (int i = 0; i < 65534; i++) step(1'b1);
        chk("bubble_preload", 64'(bubble_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) step();
        chk("bubble_sat", 64'(bubble_cnt), 64'hFFFF);
        cnt_clr = 1'b1;
        step();
        chk("bubble_clr", 64'(bubble_cnt), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
